// File: rtl/acc_ub_drain.sv
// Accumulator/Unified-Buffer drain: captures skewed column partial sums and a compensation row,
// then streams saturated row sums (acc + comp) to the UB one row per cycle.
module acc_ub_drain #(
  parameter int SIZE       = 8,
  parameter int PSUM_WIDTH = 20,
  parameter int OUT_WIDTH  = 16,
  parameter int ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SIZE-1:0]              ACC_Wr_en,
  input  logic [SIZE*PSUM_WIDTH-1:0]   Psum_in,
  input  logic                         CACC_Wr_en,
  input  logic [SIZE*PSUM_WIDTH-1:0]   CPsum_in,
  input  logic                         Acc_Rd_en,
  input  logic                         UB_Wr_en,
  input  logic                         Done,
  output logic                         UB_Valid,
  output logic [ADDR_WIDTH-1:0]        UB_Addr,
  output logic [SIZE*OUT_WIDTH-1:0]    UB_Data,
  output logic                         Drain_Done,
  output logic                         Overflow_Err
);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, FIN} state_t;
  typedef logic [ADDR_WIDTH:0] ptr_t;

  localparam ptr_t                        FULL     = ptr_t'(SIZE);
  localparam logic [ADDR_WIDTH-1:0]       LAST_ROW = ADDR_WIDTH'(SIZE - 1);
  localparam logic signed [PSUM_WIDTH:0]  SAT_MAX  = (PSUM_WIDTH + 1)'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [PSUM_WIDTH:0]  SAT_MIN  = ~SAT_MAX;

  state_t                   state_q, state_d;
  ptr_t                     wp_q [SIZE];
  ptr_t                     wp_d [SIZE];
  ptr_t                     cp_q, cp_d;
  logic [ADDR_WIDTH-1:0]    rp_q, rp_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic                     valid_q, valid_d;
  logic                     drain_done_q, drain_done_d;
  logic                     ovf_q, ovf_d;
  logic                     done_q;
  logic [SIZE-1:0]          acc_we;
  logic                     comp_we;
  logic                     issue, done_rise, capture;
  logic [SIZE*PSUM_WIDTH-1:0] comp_mem [SIZE];

  always_comb begin
    done_rise    = Done & ~done_q;
    capture      = (state_q == IDLE || state_q == COLLECT) && !done_rise;
    issue        = (state_q == DRAIN) && Acc_Rd_en && UB_Wr_en && !done_rise;
    state_d      = state_q;
    cp_d         = cp_q;
    rp_d         = rp_q;
    addr_d       = addr_q;
    valid_d      = 1'b0;
    drain_done_d = drain_done_q;
    ovf_d        = ovf_q;
    acc_we       = '0;
    comp_we      = 1'b0;
    for (int c = 0; c < SIZE; c++) wp_d[c] = wp_q[c];

    if (done_rise) begin
      state_d      = IDLE;
      cp_d         = '0;
      rp_d         = '0;
      drain_done_d = 1'b0;
      ovf_d        = 1'b0;
      for (int c = 0; c < SIZE; c++) wp_d[c] = '0;
    end else begin
      unique case (state_q)
        IDLE:    if (|ACC_Wr_en || CACC_Wr_en) state_d = COLLECT;
        COLLECT: if (Acc_Rd_en) state_d = DRAIN;
        DRAIN:   if (issue && rp_q == LAST_ROW) state_d = FIN;
        default: ;
      endcase

      // A full bank drops the write and holds its pointer; only the error flag records it.
      if (capture) begin
        for (int c = 0; c < SIZE; c++) begin
          if (ACC_Wr_en[c]) begin
            if (wp_q[c] == FULL) ovf_d = 1'b1;
            else begin
              acc_we[c] = 1'b1;
              wp_d[c]   = wp_q[c] + ptr_t'(1);
            end
          end
        end
        if (CACC_Wr_en) begin
          if (cp_q == FULL) ovf_d = 1'b1;
          else begin
            comp_we = 1'b1;
            cp_d    = cp_q + ptr_t'(1);
          end
        end
      end

      if (issue) begin
        valid_d = 1'b1;
        addr_d  = rp_q;
        rp_d    = rp_q + ADDR_WIDTH'(1);
        if (rp_q == LAST_ROW) drain_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cp_q         <= '0;
      rp_q         <= '0;
      addr_q       <= '0;
      valid_q      <= 1'b0;
      drain_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
      for (int c = 0; c < SIZE; c++) wp_q[c] <= '0;
    end else begin
      state_q      <= state_d;
      cp_q         <= cp_d;
      rp_q         <= rp_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      drain_done_q <= drain_done_d;
      ovf_q        <= ovf_d;
      done_q       <= Done;
      for (int c = 0; c < SIZE; c++) wp_q[c] <= wp_d[c];
    end
  end

  always_ff @(posedge clk) begin
    if (comp_we) comp_mem[cp_q[ADDR_WIDTH-1:0]] <= CPsum_in;
  end

  for (genvar gi = 0; gi < SIZE; gi++) begin : g_col
    logic signed [PSUM_WIDTH-1:0] acc_mem [SIZE];
    logic signed [PSUM_WIDTH-1:0] acc_rd, comp_rd;
    logic signed [PSUM_WIDTH:0]   sum;
    logic [OUT_WIDTH-1:0]         lane_d, lane_q;

    always_ff @(posedge clk) begin
      if (acc_we[gi]) acc_mem[wp_q[gi][ADDR_WIDTH-1:0]] <= Psum_in[gi*PSUM_WIDTH +: PSUM_WIDTH];
    end

    // Rows never written since rearm read as zero, so stale bank contents never leak out.
    always_comb begin
      acc_rd  = '0;
      comp_rd = '0;
      if ({1'b0, rp_q} < wp_q[gi]) acc_rd = acc_mem[rp_q];
      if ({1'b0, rp_q} < cp_q)     comp_rd = comp_mem[rp_q][gi*PSUM_WIDTH +: PSUM_WIDTH];
      sum = {acc_rd[PSUM_WIDTH-1], acc_rd} + {comp_rd[PSUM_WIDTH-1], comp_rd};
      if (sum > SAT_MAX)      lane_d = SAT_MAX[OUT_WIDTH-1:0];
      else if (sum < SAT_MIN) lane_d = SAT_MIN[OUT_WIDTH-1:0];
      else                    lane_d = sum[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
      if (rst)        lane_q <= '0;
      else if (issue) lane_q <= lane_d;
    end

    assign UB_Data[gi*OUT_WIDTH +: OUT_WIDTH] = lane_q;
  end

  assign UB_Valid     = valid_q;
  assign UB_Addr      = addr_q;
  assign Drain_Done   = drain_done_q;
  assign Overflow_Err = ovf_q;

endmodule

// File: tb/tb_acc_ub_drain.sv
// Bench for acc_ub_drain: directed patterns, expected rows queued at stimulus time and
// checked by an independent monitor whenever UB_Valid is seen.
`timescale 1ns/1ps
module tb_acc_ub_drain;
  localparam int SIZE = 8;
  localparam int PW   = 20;
  localparam int OW   = 16;
  localparam int AW   = 3;
  localparam int DW   = SIZE * OW;

  logic              clk = 1'b0;
  logic              rst;
  logic [SIZE-1:0]   ACC_Wr_en;
  logic [SIZE*PW-1:0] Psum_in;
  logic              CACC_Wr_en;
  logic [SIZE*PW-1:0] CPsum_in;
  logic              Acc_Rd_en, UB_Wr_en, Done;
  logic              UB_Valid;
  logic [AW-1:0]     UB_Addr;
  logic [DW-1:0]     UB_Data;
  logic              Drain_Done, Overflow_Err;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic signed [PW-1:0] acc_m  [SIZE+1][SIZE];
  logic signed [PW-1:0] comp_m [SIZE+1][SIZE];
  logic [OW-1:0]        exp_m  [SIZE][SIZE];
  int                   nrows [SIZE];
  int                   ncomp;

  acc_ub_drain dut (
    .clk(clk), .rst(rst), .ACC_Wr_en(ACC_Wr_en), .Psum_in(Psum_in),
    .CACC_Wr_en(CACC_Wr_en), .CPsum_in(CPsum_in), .Acc_Rd_en(Acc_Rd_en),
    .UB_Wr_en(UB_Wr_en), .Done(Done), .UB_Valid(UB_Valid), .UB_Addr(UB_Addr),
    .UB_Data(UB_Data), .Drain_Done(Drain_Done), .Overflow_Err(Overflow_Err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && UB_Valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_row: got addr %0d data %h, required no output", UB_Addr, UB_Data);
      end else begin
        e = exp_q.pop_front();
        if ({UB_Addr, UB_Data, Drain_Done} !== e) begin
          n_err++;
          $display("FAIL row%0d: got addr %0d data %h done %b, required addr %0d data %h done %b",
                   e.addr, UB_Addr, UB_Data, Drain_Done, e.addr, e.data, e.last);
        end else
          $display("row addr %0d data %h done %b ok", UB_Addr, UB_Data, Drain_Done);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else
      $display("check %s = %h ok", name, act);
  endtask

  task automatic done_pulse();
    Done = 1'b1;
    tick();
    Done = 1'b0;
    tick();
  endtask

  // Skewed capture: column c strobes row r at step r+c; compensation rows go out in steps 0..ncomp-1.
  task automatic load();
    for (int t = 0; t < 2 * SIZE; t++) begin
      ACC_Wr_en  = '0;
      CACC_Wr_en = 1'b0;
      for (int c = 0; c < SIZE; c++) begin
        int r;
        r = t - c;
        if (r >= 0 && r < nrows[c]) begin
          ACC_Wr_en[c] = 1'b1;
          Psum_in[c*PW +: PW] = acc_m[r][c];
        end
        if (t < ncomp) CPsum_in[c*PW +: PW] = comp_m[t][c];
      end
      if (t < ncomp) CACC_Wr_en = 1'b1;
      tick();
    end
    ACC_Wr_en  = '0;
    CACC_Wr_en = 1'b0;
    tick();
  endtask

  task automatic drain(input int stall_after, input int stall_len, input bit use_rd);
    exp_t e;
    int   issued, cyc;
    for (int r = 0; r < SIZE; r++) begin
      e.addr = AW'(r);
      for (int c = 0; c < SIZE; c++) e.data[c*OW +: OW] = exp_m[r][c];
      e.last = (r == SIZE - 1);
      exp_q.push_back(e);
    end
    Acc_Rd_en = 1'b1;
    UB_Wr_en  = 1'b1;
    tick();
    issued = 0;
    cyc    = 0;
    while (!Drain_Done && cyc < 60) begin
      if (stall_len > 0 && issued == stall_after) begin
        if (use_rd) Acc_Rd_en = 1'b0;
        else        UB_Wr_en  = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          chk("stall_valid", DW'(UB_Valid), DW'(0));
        end
        Acc_Rd_en = 1'b1;
        UB_Wr_en  = 1'b1;
        stall_len = 0;
      end
      tick();
      issued++;
      cyc++;
    end
    chk("drain_done_seen", DW'(Drain_Done), DW'(1));
    Acc_Rd_en = 1'b0;
    UB_Wr_en  = 1'b0;
    tick();
    chk("fin_valid", DW'(UB_Valid), DW'(0));
    chk("drain_done_sticky", DW'(Drain_Done), DW'(1));
    chk("rows_outstanding", DW'(exp_q.size()), DW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ACC_Wr_en = '0; Psum_in = '0; CACC_Wr_en = 1'b0; CPsum_in = '0;
    Acc_Rd_en = 1'b0; UB_Wr_en = 1'b0; Done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_valid", DW'(UB_Valid), DW'(0));
    chk("reset_addr", DW'(UB_Addr), DW'(0));
    chk("reset_data", UB_Data, DW'(0));
    chk("reset_drain_done", DW'(Drain_Done), DW'(0));
    chk("reset_overflow", DW'(Overflow_Err), DW'(0));

    // Nine compensation strobes overflow, then a mid-COLLECT reset must clear everything.
    CPsum_in = {SIZE{20'h00007}};
    CACC_Wr_en = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    CACC_Wr_en = 1'b0;
    tick();
    chk("comp_overflow", DW'(Overflow_Err), DW'(1));
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("midreset_overflow", DW'(Overflow_Err), DW'(0));
    chk("midreset_valid", DW'(UB_Valid), DW'(0));
    chk("midreset_data", UB_Data, DW'(0));

    // Nominal: acc = r*8+c, comp = 1.
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        acc_m[r][c]  = PW'(r * 8 + c);
        comp_m[r][c] = PW'(1);
        exp_m[r][c]  = OW'(r * 8 + c + 1);
      end
    for (int c = 0; c < SIZE; c++) nrows[c] = SIZE;
    ncomp = SIZE;
    load();
    chk("nominal_no_overflow", DW'(Overflow_Err), DW'(0));
    drain(0, 0, 1'b0);
    done_pulse();
    chk("rearm1_drain_done", DW'(Drain_Done), DW'(0));

    // Overflow: column 3 gets 9 strobes, column 5 only 5 rows, no compensation rows.
    for (int r = 0; r <= SIZE; r++)
      for (int c = 0; c < SIZE; c++) acc_m[r][c] = PW'(r * 8 + c);
    for (int r = 0; r <= SIZE; r++) acc_m[r][3] = PW'(500 + r);
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        if (c == 3)      exp_m[r][c] = OW'(500 + r);
        else if (c == 5) exp_m[r][c] = (r < 5) ? OW'(r * 8 + 5) : OW'(0);
        else             exp_m[r][c] = OW'(r * 8 + c);
      end
    for (int c = 0; c < SIZE; c++) nrows[c] = SIZE;
    nrows[3] = SIZE + 1;
    nrows[5] = 5;
    ncomp = 0;
    load();
    chk("acc_overflow", DW'(Overflow_Err), DW'(1));
    drain(4, 2, 1'b1);
    chk("overflow_sticky", DW'(Overflow_Err), DW'(1));
    done_pulse();
    chk("rearm2_drain_done", DW'(Drain_Done), DW'(0));
    chk("rearm2_overflow", DW'(Overflow_Err), DW'(0));

    // Saturation and exact-limit boundaries; UB_Wr_en stalls 3 cycles after row 2.
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        bit even;
        even = (c % 2 == 0);
        comp_m[r][c] = PW'(0);
        if (r < 4) begin
          acc_m[r][c]  = even ? 20'h7FFFF : 20'h80000;
          comp_m[r][c] = even ? 20'h7FFFF : 20'hFFFFF;
          exp_m[r][c]  = even ? 16'h7FFF : 16'h8000;
        end else if (r < 6) begin
          acc_m[r][c]  = PW'(-300);
          comp_m[r][c] = PW'(c);
          exp_m[r][c]  = OW'(c - 300);
        end else if (r == 6) begin
          acc_m[r][c]  = even ? PW'(32768) : PW'(-32769);
          exp_m[r][c]  = even ? 16'h7FFF : 16'h8000;
        end else begin
          acc_m[r][c]  = even ? PW'(32767) : PW'(-32768);
          exp_m[r][c]  = even ? 16'h7FFF : 16'h8000;
        end
      end
    for (int c = 0; c < SIZE; c++) nrows[c] = SIZE;
    ncomp = SIZE;
    load();
    chk("sat_no_overflow", DW'(Overflow_Err), DW'(0));
    drain(3, 3, 1'b0);
    done_pulse();
    chk("rearm3_drain_done", DW'(Drain_Done), DW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
